// File: rtl/cnn_pkg.sv
// Shared CNN dimensions and the pooling stage state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnn_pkg;

    localparam int IN_WIDTH       = 28;
    localparam int CONV_OUT_WIDTH = 26;
    localparam int POOL_OUT_WIDTH = 13;
    localparam int DATA_W         = 16;

    typedef enum logic [1:0] {
        POOL_IDLE = 2'd0,
        POOL_RUN  = 2'd1,
        POOL_DONE = 2'd2
    } pool_state_t;

endpackage

// File: rtl/pool_line_buffer.sv
// Line buffer holding the horizontal pair maxima of the last even row.
// Latency: synchronous write, combinational read.
// Backpressure: none; written at most once per accepted beat.
module pool_line_buffer #(
    parameter int DEPTH  = 13,
    parameter int DATA_W = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/relu_maxpool_stage.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-order conv stream.
// Latency: one cycle from the odd-row/odd-col input beat to out_valid.
// Backpressure: none; one beat per cycle accepted, sink must take every output.
module relu_maxpool_stage #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IN_DIM = cnn_pkg::CONV_OUT_WIDTH,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done
);
    import cnn_pkg::*;

    localparam int HALF = IN_DIM / 2;
    localparam int CW   = $clog2(IN_DIM);
    localparam int LAW  = (HALF > 1) ? $clog2(HALF) : 1;

    pool_state_t       state, state_nxt;
    logic [CW-1:0]     row, col;
    logic [ADDR_W-1:0] pool_idx;
    logic [DATA_W-1:0] r, pair_max, lb_rd, pm_r, lb_r;
    logic [LAW-1:0]    lb_idx;
    logic              accept, col_last, row_last, lb_we;

    assign accept   = (state == POOL_RUN) && in_valid;
    assign col_last = (col == CW'(IN_DIM - 1));
    assign row_last = (row == CW'(IN_DIM - 1));
    assign lb_idx   = LAW'(col >> 1);

    // Sign bit set means negative (including the most negative code): clamp to 0.
    assign r    = in_data[DATA_W-1] ? '0 : in_data;
    assign pm_r = (pair_max > r) ? pair_max : r;
    assign lb_r = (lb_rd > r) ? lb_rd : r;

    // Even rows fold each horizontal pair into the buffer; odd rows consume it.
    assign lb_we = accept && !row[0] && col[0];

    pool_line_buffer #(
        .DEPTH  (HALF),
        .DATA_W (DATA_W),
        .AW     (LAW)
    ) u_lbuf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (lb_idx),
        .wr_data (pm_r),
        .rd_addr (lb_idx),
        .rd_data (lb_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= POOL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            POOL_IDLE: if (start) state_nxt = POOL_RUN;
            POOL_RUN:  if (accept && row_last && col_last) state_nxt = POOL_DONE;
            POOL_DONE: if (!start) state_nxt = POOL_IDLE;
            default:   state_nxt = POOL_IDLE;
        endcase
    end

    always_comb begin
        done = (state == POOL_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            pool_idx  <= '0;
            pair_max  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == POOL_IDLE && start) begin
                row      <= '0;
                col      <= '0;
                pool_idx <= '0;
                out_addr <= '0;
            end else if (accept) begin
                col <= col_last ? '0 : col + CW'(1);
                if (col_last) begin
                    row <= row_last ? '0 : row + CW'(1);
                end
                if (!col[0]) begin
                    pair_max <= row[0] ? lb_r : r;
                end else if (row[0]) begin
                    out_valid <= 1'b1;
                    out_data  <= pm_r;
                    out_addr  <= pool_idx;
                    pool_idx  <= pool_idx + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Randomized bench for relu_maxpool_stage against a frame-level pooling model.
module tb_relu_maxpool_stage;

    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int DIM  = 26;
    localparam int PDIM = DIM / 2;
    localparam int NPIX = DIM * DIM;
    localparam int NOUT = PDIM * PDIM;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          done;

    relu_maxpool_stage #(.DATA_W(DW), .IN_DIM(DIM), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    int   frame [NPIX];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   nout, first_data, first_addr, last_data, last_addr;
    bit   mon_ev;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    // Expected pooled value of the window whose bottom-right pixel is (r, c).
    function automatic int window_max(input int r, input int c);
        int m = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (relu(frame[(r - 1 + i) * DIM + c - 1 + j]) > m)
                    m = relu(frame[(r - 1 + i) * DIM + c - 1 + j]);
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            mon_ev = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", int'(out_valid), int'(mon_ev));
            if (mon_ev) begin
                if (out_valid) begin
                    chk("out_data", int'(out_data), q[0].data);
                    chk("out_addr", int'(out_addr), q[0].addr);
                    if (nout == 0) begin
                        first_data = int'(out_data);
                        first_addr = int'(out_addr);
                    end
                    last_data = int'(out_data);
                    last_addr = int'(out_addr);
                    nout++;
                end
                void'(q.pop_front());
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic do_start();
        nout = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // gap >= 0: fixed idle cycles before each beat; gap < 0: random 0..2.
    task automatic drive_frame(input int gap, input int nbeats);
        exp_t e;
        int r, c;
        for (int idx = 0; idx < nbeats; idx++) begin
            repeat ((gap < 0) ? $urandom_range(2, 0) : gap) idle_cycle();
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = DW'(frame[idx]);
            r = idx / DIM;
            c = idx % DIM;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                e.due  = cyc + 1;
                e.addr = (r / 2) * PDIM + c / 2;
                e.data = window_max(r, c);
                q.push_back(e);
            end
            if (idx == NPIX - 1) begin
                @(negedge clk);
                chk("done_before_last", int'(done), 0);
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_last_coincide"}, int'(out_valid), 1);
        repeat (3) @(negedge clk);
        chk({tag, "_nout"}, nout, NOUT);
        chk({tag, "_done_cleared"}, int'(done), 0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NPIX; i++) frame[i] = i;
    endtask

    task automatic check_ramp_ends(input string tag);
        chk({tag, "_first_data"}, first_data, 27);
        chk({tag, "_first_addr"}, first_addr, 0);
        chk({tag, "_last_data"}, last_data, 675);
        chk({tag, "_last_addr"}, last_addr, NOUT - 1);
    endtask

    int vals [4];
    int w, corner;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        nout     = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_addr", int'(out_addr), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Beats while idle must be ignored; the monitor flags any out_valid.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            in_data  = DW'(i * 1000 + 7);
        end
        idle_cycle();
        repeat (2) @(negedge clk);
        chk("idle_done", int'(done), 0);
        chk("idle_nout", nout, 0);

        fill_ramp();
        do_start();
        drive_frame(0, NPIX);
        finish_frame("ramp");
        check_ramp_ends("ramp");

        for (int i = 0; i < NPIX; i++)
            frame[i] = (i % 7 == 0) ? -32768 : -int'($urandom_range(32767, 1));
        do_start();
        drive_frame(0, NPIX);
        finish_frame("neg");

        fill_ramp();
        do_start();
        drive_frame(2, NPIX);
        finish_frame("sparse");
        check_ramp_ends("sparse");

        for (int i = 0; i < NPIX; i++) begin
            w      = (i / DIM / 2) * PDIM + (i % DIM) / 2;
            corner = ((i / DIM) % 2) * 2 + (i % DIM) % 2;
            frame[i] = (corner == w % 4) ? 100 : 5;
        end
        do_start();
        drive_frame(-1, NPIX);
        finish_frame("corner");
        chk("corner_last", last_data, 100);

        vals[0] = -7; vals[1] = 3; vals[2] = 0; vals[3] = 2;
        for (int i = 0; i < NPIX; i++) begin
            w      = (i / DIM / 2) * PDIM + (i % DIM) / 2;
            corner = ((i / DIM) % 2) * 2 + (i % DIM) % 2;
            frame[i] = vals[(corner + w) % 4];
        end
        do_start();
        drive_frame(0, NPIX);
        finish_frame("mixed");
        chk("mixed_first", first_data, 3);

        for (int i = 0; i < NPIX; i++) frame[i] = int'($urandom_range(65535, 0)) - 32768;
        do_start();
        drive_frame(-1, NPIX);
        finish_frame("random");

        for (int i = 0; i < NPIX; i++) frame[i] = int'($urandom_range(65535, 0)) - 32768;
        do_start();
        drive_frame(0, 300);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_addr", int'(out_addr), 0);
        chk("midrst_done", int'(done), 0);
        fill_ramp();
        do_start();
        drive_frame(0, NPIX);
        finish_frame("after_rst");
        check_ramp_ends("after_rst");

        // start held high across the whole frame and into DONE
        for (int i = 0; i < NPIX; i++) frame[i] = int'($urandom_range(65535, 0)) - 32768;
        nout = 0;
        @(posedge clk);
        #1 start = 1'b1;
        drive_frame(0, NPIX);
        @(negedge clk);
        chk("hold_done", int'(done), 1);
        repeat (4) begin
            @(negedge clk);
            chk("hold_done_stays", int'(done), 1);
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("hold_done_until_edge", int'(done), 1);
        @(negedge clk);
        chk("hold_done_dropped", int'(done), 0);
        chk("hold_nout", nout, NOUT);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
